// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide controller.
// The iterative datapath and the controller both import this package.
package hilo_muldiv_ctrl_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV0_LO    = 32'hFFFFFFFF;

  // Two's-complement magnitude when en is set, raw value otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle multiply/divide datapath over unsigned magnitudes.
// Multiply is shift-add into {acc_hi, acc_lo}; divide is restoring with acc_hi as remainder.
module muldiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_is_div,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [31:0] r_b;

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_ge;

  // The partial remainder always stays below the divisor, so the low 32 bits
  // of the difference are exact whenever the subtract is taken.
  always_comb begin
    w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : 33'd0);
    w_shift = {r_acc_hi, r_acc_lo[31]};
    w_diff  = w_shift[31:0] - r_b;
    w_ge    = (w_shift >= {1'b0, r_b});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_b      <= 32'd0;
    end else if (i_load) begin
      r_acc_hi <= 32'd0;
      r_acc_lo <= i_a;
      r_b      <= i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        r_acc_hi <= w_ge ? w_diff : w_shift[31:0];
        r_acc_lo <= {r_acc_lo[30:0], w_ge};
      end else begin
        r_acc_hi <= w_sum[32:1];
        r_acc_lo <= {w_sum[0], r_acc_lo[31:1]};
      end
    end
  end

  assign o_hi = r_acc_hi;
  assign o_lo = r_acc_lo;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register file with a 32-iteration multiply/divide sequencer.
// Handshake: start is taken only in IDLE; busy covers CALC and FIX; done pulses once when HI/LO update.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        mf_req,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done
);

  localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

  state_e      r_state;
  logic [4:0]  r_count;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_b_zero;
  logic [31:0] r_a_raw;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_is_mul;
  logic        w_is_signed;
  logic        w_load;
  logic        w_step;
  logic [31:0] w_iter_hi;
  logic [31:0] w_iter_lo;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_load      = (r_state == ST_IDLE) && start && !flush;
  assign w_step      = (r_state == ST_CALC) && !flush;

  muldiv_iter u_iter (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (r_is_div),
    .i_a      (abs32(a, w_is_signed)),
    .i_b      (abs32(b, w_is_signed)),
    .o_hi     (w_iter_hi),
    .o_lo     (w_iter_lo)
  );

  // Sign fix-up; divide by zero bypasses the datapath result entirely.
  always_comb begin
    w_prod = {w_iter_hi, w_iter_lo};
    if (r_neg_q) w_prod = ~w_prod + 64'd1;
    w_quot = r_neg_q ? (~w_iter_lo + 32'd1) : w_iter_lo;
    w_rem  = r_neg_r ? (~w_iter_hi + 32'd1) : w_iter_hi;
    if (!r_is_div) begin
      w_fix_hi = w_prod[63:32];
      w_fix_lo = w_prod[31:0];
    end else if (r_b_zero) begin
      w_fix_hi = r_a_raw;
      w_fix_lo = DIV0_LO;
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_a_raw  <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
      if (flush) begin
        r_state <= ST_IDLE;
        r_count <= 5'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_is_div <= !w_is_mul;
              r_neg_q  <= w_is_signed && (a[31] ^ b[31]);
              r_neg_r  <= w_is_signed && a[31];
              r_b_zero <= (b == 32'd0);
              r_a_raw  <= a;
              r_count  <= 5'd0;
              r_state  <= ST_CALC;
            end
          end
          ST_CALC: begin
            if (r_count == LAST_ITER) begin
              r_count <= 5'd0;
              r_state <= ST_FIX;
            end else begin
              r_count <= r_count + 5'd1;
            end
          end
          ST_FIX: begin
            // Overrides any mthi/mtlo landing on the same edge.
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign hi    = r_hi;
  assign lo    = r_lo;
  assign done  = r_done;
  assign busy  = (r_state != ST_IDLE);
  assign stall = busy && (start || mf_req) && !rst;

endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 The block SHALL have a single clock port, clk; every register updates on its rising edge.
REQ-002 The block SHALL have a reset port, rst, which is asynchronous and active-high.
REQ-003 Ports, one per line as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  issue a mult/div from ID
- op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
- a  in  32  rs operand
- b  in  32  rt operand
- flush  in  1  abort the in-flight operation
- mf_req  in  1  ID wants to read HI or LO (mfhi/mflo)
- hi_we  in  1  mthi write
- lo_we  in  1  mtlo write
- wdata  in  32  mthi/mtlo data
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight
- stall  out  1  freeze the front end
- done  out  1  one-cycle completion pulse

Function
REQ-004 States SHALL be IDLE, CALC and FIX.
REQ-005 In IDLE, when start=1 at edge E0, the block SHALL capture op, |a| and |b| (raw values for MULTU/DIVU), and the result signs; it SHALL then enter CALC with count=0.
REQ-006 CALC SHALL run exactly 32 iterations on edges E1..E32.
- Multiply: shift-add, 64-bit accumulator.
- Divide: restoring, one quotient bit per edge.
REQ-007 At E33 (FIX) the block SHALL write HI and LO and return to IDLE.
- Results are sign-fixed for MULT/DIV.
- Quotient sign = sa^sb; remainder sign = sa.
REQ-008 done SHALL be 1 for exactly the cycle following E33; hi/lo SHALL show the new values in that same cycle.
REQ-009 busy SHALL be 1 from after E0 through E33 inclusive of the FIX cycle (33 cycles); it SHALL be 0 in IDLE.
REQ-010 stall SHALL equal busy AND (start OR mf_req); it is combinational and has no registered delay.
REQ-011 start while busy SHALL be ignored; the issuing instruction is held by stall.
REQ-012 Multiply results SHALL be HI=product[63:32] and LO=product[31:0].
REQ-013 Divide results SHALL be LO=quotient and HI=remainder.
REQ-014 Divide by zero (b=0) SHALL still take 33 cycles.
- LO=32'hFFFFFFFF, HI=a (raw dividend), signed or unsigned.
REQ-015 Signed overflow (a=32'h80000000, b=32'hFFFFFFFF, DIV) SHALL give LO=32'h80000000 and HI=0.
REQ-016 In IDLE, hi_we/lo_we SHALL write wdata to HI/LO at the next edge.
REQ-017 hi_we/lo_we while busy SHALL update the addressed register immediately; the FIX write still overwrites both registers.
REQ-018 If hi_we and FIX coincide on one edge, the FIX result SHALL win.
REQ-019 flush=1 SHALL have the following effect:
- In any state, return to IDLE at the next edge.
- HI/LO are left unchanged and done is not pulsed.
- flush has priority over start on the same edge.
REQ-020 start with flush=0 on the same edge that FIX completes SHALL be ignored; IDLE accepts it on the next cycle.

Reset
REQ-021 rst=1 SHALL immediately force the following, independent of clk:
- state=IDLE, count=0, hi=0, lo=0.
- busy=0, done=0, internal accumulators=0.
REQ-022 stall SHALL be 0 while rst=1.
REQ-023 Reset asserted mid-operation SHALL discard the operation; no HI/LO write occurs after reset is released.

Structure
REQ-024 A shared package SHALL hold the following:
- Op encodings MULT/MULTU/DIV/DIVU.
- The state enum IDLE/CALC/FIX.
- ITER_COUNT=32 and DIV0_LO=32'hFFFFFFFF.
REQ-025 The iterative datapath SHALL be one sub-module, muldiv_iter, covering the accumulator, shift and subtract.
- The FSM, sign fix-up and HI/LO registers stay in hilo_muldiv_ctrl.

Verification
REQ-026 MULT a=32'hFFFFFFFD, b=5 SHALL give hi=32'hFFFFFFFF, lo=32'hFFFFFFF1, with done exactly 33 cycles after start.
REQ-027 MULTU a=32'hFFFFFFFF, b=2 SHALL give hi=1, lo=32'hFFFFFFFE; DIV a=-7, b=2 SHALL give lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-028 DIVU a=7, b=0 SHALL give lo=32'hFFFFFFFF, hi=7; DIV 32'h80000000 / -1 SHALL give lo=32'h80000000, hi=0.
REQ-029 With mf_req=1 at cycle 5 of a busy operation, stall SHALL be 1 until the FIX cycle ends and 0 in the done cycle.
REQ-030 Preload hi=32'h1234, then assert flush at cycle 10 of a DIV:
- Required: busy=0 next cycle, hi=32'h1234 retained, no done pulse.
REQ-031 Reset asserted at cycle 20 of a MULT:
- Required: outputs zero immediately, and no done or HI/LO change after release.
- mthi 32'hAB in IDLE gives hi=32'hAB next cycle.
